id_ex_skid: RTL and testbench
=============================

# id_ex_skid

Parametrised ID→EX pipeline register, successor to the fixed-width ID/EX latch. It adds a valid/ready handshake, a one-entry skid buffer so a stalled EX stage never drops a decoded instruction, and synchronous flush for branch/exception squash. The block sits between the decode stage and the ALU/EX stage, and latches on the falling edge of `clock` like the rest of the pipeline registers.

## Interface
Parameters:
- `DATA_W`, 32: width of `registerFileDataA/B`, `pcpp` and `extendedSignal`.
- `REG_ADDR_W`, 4: width of `registerFileWrite`.
- `ALUOP_W`, 5: width of `ALUOp`.

Ports:
- `clock` in 1: pipeline clock; all state updates on the negedge.
- `reset_n` in 1: asynchronous active-low reset.
- `flush` in 1: squashes all held entries.
- `in_valid` in 1: decode presents an instruction.
- `in_ready` out 1: block can accept; registered.
- `registerFileDataA_in`, `registerFileDataB_in`, `pcpp_in`, `extendedSignal_in` in DATA_W each: payload.
- `registerFileWrite_in` in REG_ADDR_W: payload.
- `ALUOp_in` in ALUOP_W: payload.
- `ALUSrc_in`, `memRead_in`, `memWrite_in`, `memToReg_in`, `regWrite_in` in 1 each: payload.
- `out_valid` out 1: output stage holds an instruction.
- `out_ready` in 1: EX consumes this edge.
- Matching outputs without the `_in` suffix, same widths.
- `stallCount`, `bubbleCount` out 32 each: present only with `IDEX_PERF_CNT_EN`.

## Operation
- There are two storage slots: the output register (OUT) and the skid register (SKID). Each slot has a valid bit.
- State is named by occupancy: EMPTY (neither valid), ONE (OUT valid), FULL (OUT and SKID valid). SKID valid without OUT valid is illegal.
- Accept: `in_valid & in_ready` at a negedge.
- Consume: `out_valid & out_ready` at a negedge.
- EMPTY + accept → ONE, and the payload loads into OUT.
- ONE + consume + accept → ONE, and OUT is replaced by the new payload.
- ONE + consume, no accept → EMPTY.
- ONE + accept, no consume → FULL, and the payload loads into SKID.
- FULL + consume → ONE, and SKID moves to OUT. `in_ready` is 0 in FULL, so no accept happens.
- `in_ready` is registered and equals !SKID valid. It never depends combinationally on `out_ready`.
- `flush` has the highest priority: both valid bits clear at the next negedge and the state goes to EMPTY. Any accept or consume in that cycle is ignored. Payload registers keep their contents.
- Side-effect outputs `memRead`, `memWrite` and `regWrite` equal the stored bit AND `out_valid`. A bubble can never write memory or registers.
- All other outputs show the OUT payload unconditionally.

## Timing
- Reset (async, `reset_n`=0):
  - All valid bits, all payload registers and all outputs are 0.
  - `in_ready`=1, `out_valid`=0.
  - Counters are 0.
- Reset release is synchronised by the next negedge. The first accept is possible on the first negedge with `reset_n`=1.
- Latency: an accept into EMPTY or ONE-with-consume is visible on the outputs immediately after that negedge (1 edge). Through SKID, latency is 1 edge plus the stall length.
- Throughput is 1 instruction per clock while `out_ready`=1.
- Reset asserted mid-stall discards both entries immediately, with no handshake.
- Payload must be held stable by decode only at the accepting edge. The block never samples the payload without accept.

## Configuration
- `IDEX_PERF_CNT_EN` defined:
  - Adds `stallCount`, which increments on each negedge with `out_valid & !out_ready`.
  - Adds `bubbleCount`, which increments on each negedge with `!out_valid`.
  - Both are 32-bit, saturate at 0xFFFFFFFF, are cleared by reset, and are not cleared by `flush`.
- Not defined: the ports and logic are absent, and the handshake behaviour is identical.

## Structure
- Shared package `pipe_pkg`:
  - Payload struct type `idex_payload_t`, built from the three width parameters.
  - Default widths as constants.
  - State encoding constants EMPTY/ONE/FULL.
- One sub-module `pipe_skid_slot`: a single valid+payload register with load/clear, instantiated twice (OUT, SKID).
- Occupancy control and output gating live in the top level.

## Test plan
- Reset with `in_valid`=1 and `registerFileDataA_in`=0x1234 → all outputs 0, `in_ready`=1, `out_valid`=0. The first negedge after release captures 0x1234.
- Streaming: 4 accepts with `pcpp_in`=4,8,12,16 and `out_ready`=1 → `pcpp` shows 4,8,12,16 on consecutive edges, and `in_ready` stays 1.
- Stall: accept A (`pcpp`=0x10), then `out_ready`=0 while offering B (0x14) → B goes to SKID and `in_ready`=0. Raise `out_ready` → outputs 0x10, then 0x14, with no loss or duplication.
- Flush in FULL with `out_ready`=1 → next edge `out_valid`=0, `in_ready`=1, and `memWrite`=`regWrite`=0 even though the stored bits are 1.
- Async reset asserted between edges while FULL → `out_valid` drops immediately without a clock.
- With `IDEX_PERF_CNT_EN`: 3 stall edges and 2 empty edges → `stallCount`=3, `bubbleCount`=2. Preload near max → holds at 0xFFFFFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the ID->EX pipeline register slice.
//   - default payload widths
//   - idex_payload_t, the decoded-instruction payload at the default widths
//   - idex_state_t, occupancy encoding {SKID valid, OUT valid}
//   - idex_payload_w(), packed payload width for arbitrary widths
package pipe_pkg;

    localparam int IDEX_DATA_W     = 32;
    localparam int IDEX_REG_ADDR_W = 4;
    localparam int IDEX_ALUOP_W    = 5;

    // Number of single-bit control fields carried in the payload.
    localparam int IDEX_CTRL_BITS  = 5;

    // Encoded as {skid_valid, out_valid} so the state can be read directly
    // from the two slot valid bits; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } idex_state_t;

    typedef struct packed {
        logic [IDEX_DATA_W-1:0]     registerFileDataA;
        logic [IDEX_DATA_W-1:0]     registerFileDataB;
        logic [IDEX_DATA_W-1:0]     pcpp;
        logic [IDEX_DATA_W-1:0]     extendedSignal;
        logic [IDEX_REG_ADDR_W-1:0] registerFileWrite;
        logic [IDEX_ALUOP_W-1:0]    ALUOp;
        logic                       ALUSrc;
        logic                       memRead;
        logic                       memWrite;
        logic                       memToReg;
        logic                       regWrite;
    } idex_payload_t;

    function automatic int idex_payload_w(input int data_w, input int addr_w, input int aluop_w);
        return 4 * data_w + addr_w + aluop_w + IDEX_CTRL_BITS;
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// pipe_skid_slot: one valid bit plus payload register, updated on the falling
// edge of clock.
//   clock   in  : pipeline clock (negedge active)
//   reset_n in  : asynchronous active-low reset, clears valid and payload
//   load    in  : capture d and set valid
//   clear   in  : drop valid (wins over load); payload is left untouched
//   d       in  : payload to capture
//   vld     out : slot holds an entry
//   q       out : stored payload
module pipe_skid_slot #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         vld,
    output logic [W-1:0] q
);

    logic         vld_d, vld_q;
    logic [W-1:0] pay_d, pay_q;

    always_comb begin
        vld_d = vld_q;
        pay_d = pay_q;
        if (clear) begin
            vld_d = 1'b0;
        end else if (load) begin
            vld_d = 1'b1;
            pay_d = d;
        end
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= 1'b0;
            pay_q <= '0;
        end else begin
            vld_q <= vld_d;
            pay_q <= pay_d;
        end
    end

    assign vld = vld_q;
    assign q   = pay_q;

endmodule

// File: rtl/id_ex_skid.sv
// id_ex_skid: ID->EX pipeline register with valid/ready handshake, a one-entry
// skid buffer and synchronous flush. All state changes on the negedge of clock.
//   clock, reset_n          : clock (negedge active), async active-low reset
//   flush                   : squash every held entry at the next negedge
//   in_valid / in_ready     : decode-side handshake; in_ready is registered
//   *_in                    : decoded-instruction payload
//   out_valid / out_ready   : EX-side handshake
//   registerFileDataA ...   : OUT slot payload; memRead/memWrite/regWrite
//                             are additionally gated by out_valid
//   stallCount, bubbleCount : saturating 32-bit performance counters, only
//                             present when IDEX_PERF_CNT_EN is defined
module id_ex_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W     = IDEX_DATA_W,
    parameter int REG_ADDR_W = IDEX_REG_ADDR_W,
    parameter int ALUOP_W    = IDEX_ALUOP_W
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     registerFileDataA_in,
    input  logic [DATA_W-1:0]     registerFileDataB_in,
    input  logic [DATA_W-1:0]     pcpp_in,
    input  logic [DATA_W-1:0]     extendedSignal_in,
    input  logic [REG_ADDR_W-1:0] registerFileWrite_in,
    input  logic [ALUOP_W-1:0]    ALUOp_in,
    input  logic                  ALUSrc_in,
    input  logic                  memRead_in,
    input  logic                  memWrite_in,
    input  logic                  memToReg_in,
    input  logic                  regWrite_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     registerFileDataA,
    output logic [DATA_W-1:0]     registerFileDataB,
    output logic [DATA_W-1:0]     pcpp,
    output logic [DATA_W-1:0]     extendedSignal,
    output logic [REG_ADDR_W-1:0] registerFileWrite,
    output logic [ALUOP_W-1:0]    ALUOp,
    output logic                  ALUSrc,
    output logic                  memRead,
    output logic                  memWrite,
    output logic                  memToReg,
    output logic                  regWrite
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [31:0]           stallCount,
    output logic [31:0]           bubbleCount
`endif
);

    localparam int PAY_W = idex_payload_w(DATA_W, REG_ADDR_W, ALUOP_W);

    logic [PAY_W-1:0] in_pay, out_pay, skid_pay, out_load_pay;
    logic             out_vld, skid_vld;
    logic             out_load, out_clr, skid_load, skid_clr, out_src_skid;
    logic             accept, consume;
    idex_state_t      state;

    // Raw stored side-effect bits, gated by out_valid before leaving the block.
    logic             mem_read_s, mem_write_s, reg_write_s;

    assign in_pay = {registerFileDataA_in, registerFileDataB_in, pcpp_in, extendedSignal_in,
                     registerFileWrite_in, ALUOp_in, ALUSrc_in, memRead_in, memWrite_in,
                     memToReg_in, regWrite_in};

    // in_ready comes straight from the SKID valid flop, so it never has a
    // combinational path from out_ready.
    assign in_ready  = !skid_vld;
    assign out_valid = out_vld;
    assign accept    = in_valid & in_ready;
    assign consume   = out_vld & out_ready;
    assign state     = idex_state_t'({skid_vld, out_vld});

    always_comb begin
        out_load     = 1'b0;
        out_clr      = 1'b0;
        skid_load    = 1'b0;
        skid_clr     = 1'b0;
        out_src_skid = 1'b0;
        if (flush) begin
            out_clr  = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) out_load = 1'b1;
                end
                ONE: begin
                    if (consume && accept) out_load  = 1'b1;
                    else if (consume)      out_clr   = 1'b1;
                    else if (accept)       skid_load = 1'b1;
                end
                FULL: begin
                    // in_ready is low here, so only the drain can happen.
                    if (consume) begin
                        out_load     = 1'b1;
                        out_src_skid = 1'b1;
                        skid_clr     = 1'b1;
                    end
                end
                default: begin
                    // SKID valid without OUT valid: recover to EMPTY.
                    out_clr  = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    assign out_load_pay = out_src_skid ? skid_pay : in_pay;

    // ---- storage slots (negedge) ----
    pipe_skid_slot #(.W(PAY_W)) u_out_slot (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (out_load),
        .clear   (out_clr),
        .d       (out_load_pay),
        .vld     (out_vld),
        .q       (out_pay)
    );

    pipe_skid_slot #(.W(PAY_W)) u_skid_slot (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (skid_load),
        .clear   (skid_clr),
        .d       (in_pay),
        .vld     (skid_vld),
        .q       (skid_pay)
    );

    // ---- output decode ----
    assign {registerFileDataA, registerFileDataB, pcpp, extendedSignal,
            registerFileWrite, ALUOp, ALUSrc, mem_read_s, mem_write_s,
            memToReg, reg_write_s} = out_pay;

    assign memRead  = mem_read_s  & out_vld;
    assign memWrite = mem_write_s & out_vld;
    assign regWrite = reg_write_s & out_vld;

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] stall_cnt_d, stall_cnt_q;
    logic [31:0] bubble_cnt_d, bubble_cnt_q;

    // Counters saturate and deliberately ignore flush.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (out_vld && !out_ready && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (!out_vld && bubble_cnt_q != 32'hFFFF_FFFF)
            bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stallCount  = stall_cnt_q;
    assign bubbleCount = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_skid.sv
module tb_id_ex_skid;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [31:0] ext;
        logic [3:0]  rw;
        logic [4:0]  op;
        logic        alusrc;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        rwe;
    } pay_t;

    typedef struct {
        logic        vin;
        logic        ordy;
        logic        fl;
        logic [31:0] pc;
        logic [4:0]  ctl;
        logic        e_ir;
        logic        e_ov;
    } vec_t;

    logic        clock;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] registerFileDataA_in, registerFileDataB_in, pcpp_in, extendedSignal_in;
    logic [3:0]  registerFileWrite_in;
    logic [4:0]  ALUOp_in;
    logic        ALUSrc_in, memRead_in, memWrite_in, memToReg_in, regWrite_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] registerFileDataA, registerFileDataB, pcpp, extendedSignal;
    logic [3:0]  registerFileWrite;
    logic [4:0]  ALUOp;
    logic        ALUSrc, memRead, memWrite, memToReg, regWrite;
`ifdef IDEX_PERF_CNT_EN
    logic [31:0] stallCount, bubbleCount;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    pay_t sb[$];

    id_ex_skid dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .flush                (flush),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .registerFileDataA_in (registerFileDataA_in),
        .registerFileDataB_in (registerFileDataB_in),
        .pcpp_in              (pcpp_in),
        .extendedSignal_in    (extendedSignal_in),
        .registerFileWrite_in (registerFileWrite_in),
        .ALUOp_in             (ALUOp_in),
        .ALUSrc_in            (ALUSrc_in),
        .memRead_in           (memRead_in),
        .memWrite_in          (memWrite_in),
        .memToReg_in          (memToReg_in),
        .regWrite_in          (regWrite_in),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .registerFileDataA    (registerFileDataA),
        .registerFileDataB    (registerFileDataB),
        .pcpp                 (pcpp),
        .extendedSignal       (extendedSignal),
        .registerFileWrite    (registerFileWrite),
        .ALUOp                (ALUOp),
        .ALUSrc               (ALUSrc),
        .memRead              (memRead),
        .memWrite             (memWrite),
        .memToReg             (memToReg),
        .regWrite             (regWrite)
`ifdef IDEX_PERF_CNT_EN
        ,
        .stallCount           (stallCount),
        .bubbleCount          (bubbleCount)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic pay_t mk(input logic [31:0] pc, input logic [4:0] ctl);
        pay_t p;
        p.a   = pc * 32'd3 + 32'd1;
        p.b   = ~pc;
        p.pc  = pc;
        p.ext = pc ^ 32'h5A5A_0F0F;
        p.rw  = pc[5:2];
        p.op  = pc[6:2] ^ 5'h0A;
        {p.alusrc, p.mr, p.mw, p.m2r, p.rwe} = ctl;
        return p;
    endfunction

    task automatic drive(input logic vin, input logic ordy, input logic fl, input pay_t p);
        in_valid             = vin;
        out_ready            = ordy;
        flush                = fl;
        registerFileDataA_in = p.a;
        registerFileDataB_in = p.b;
        pcpp_in              = p.pc;
        extendedSignal_in    = p.ext;
        registerFileWrite_in = p.rw;
        ALUOp_in             = p.op;
        ALUSrc_in            = p.alusrc;
        memRead_in           = p.mr;
        memWrite_in          = p.mw;
        memToReg_in          = p.m2r;
        regWrite_in          = p.rwe;
    endtask

    // Compare DUT outputs (sampled on posedge, away from the negedge) against
    // the scoreboard head.
    task automatic check_state();
        pay_t e;
        chk("in_ready", {63'd0, in_ready}, {63'd0, sb.size() < 2});
        chk("out_valid", {63'd0, out_valid}, {63'd0, sb.size() > 0});
        if (sb.size() > 0) begin
            e = sb[0];
            chk("dataA", {32'd0, registerFileDataA}, {32'd0, e.a});
            chk("dataB", {32'd0, registerFileDataB}, {32'd0, e.b});
            chk("pcpp", {32'd0, pcpp}, {32'd0, e.pc});
            chk("ext", {32'd0, extendedSignal}, {32'd0, e.ext});
            chk("regWrAddr", {60'd0, registerFileWrite}, {60'd0, e.rw});
            chk("ALUOp", {59'd0, ALUOp}, {59'd0, e.op});
            chk("ctrl", {59'd0, ALUSrc, memRead, memWrite, memToReg, regWrite},
                {59'd0, e.alusrc, e.mr, e.mw, e.m2r, e.rwe});
        end else begin
            chk("bubble_gating", {61'd0, memRead, memWrite, regWrite}, 64'd0);
        end
    endtask

    // One clock: check, drive, update scoreboard, let the negedge happen,
    // return on the following posedge.
    task automatic cycle(input logic vin, input logic ordy, input logic fl, input pay_t p);
        logic m_ir;
        logic m_ov;
        check_state();
        drive(vin, ordy, fl, p);
        m_ir = (sb.size() < 2);
        m_ov = (sb.size() > 0);
        if (fl) begin
            sb.delete();
        end else begin
            if (m_ov && ordy) void'(sb.pop_front());
            if (vin && m_ir) sb.push_back(p);
        end
        @(negedge clock);
        @(posedge clock);
    endtask

    vec_t vecs[15];
    pay_t p, idle;

    initial begin
        idle = mk(32'h0, 5'b0);
        // Streaming
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'd4,  5'b01010, 1'b1, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'd8,  5'b10101, 1'b1, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'd12, 5'b11111, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'd16, 5'b00001, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'd0,  5'b00000, 1'b1, 1'b0};
        // Stall into skid, offer while full, then drain
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h10, 5'b00100, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h14, 5'b01001, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h18, 5'b11111, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,  5'b00000, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,  5'b00000, 1'b1, 1'b0};
        // Fill with side-effect entries, flush while full
        vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h20, 5'b00101, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h24, 5'b00111, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 32'h28, 5'b00101, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h30, 5'b11111, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h0,  5'b00000, 1'b1, 1'b0};

        // Reset held with a valid instruction offered
        reset_n = 1'b0;
        p = mk(32'h40, 5'b11111);
        p.a = 32'h1234;
        drive(1'b1, 1'b1, 1'b0, p);
        @(posedge clock);
        @(posedge clock);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_data", {registerFileDataA, registerFileDataB}, 64'd0);
        chk("rst_pc_ext", {pcpp, extendedSignal}, 64'd0);
        chk("rst_misc", {55'd0, registerFileWrite, ALUOp, ALUSrc, memRead, memWrite,
                         memToReg, regWrite} , 64'd0);
`ifdef IDEX_PERF_CNT_EN
        chk("rst_counters", {stallCount, bubbleCount}, 64'd0);
`endif
        // Release between edges; the next negedge must capture 0x1234.
        reset_n = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, p);
        chk("first_capture", {32'd0, registerFileDataA}, 64'h1234);
        cycle(1'b0, 1'b1, 1'b0, idle);

        // Table-driven handshake vectors
        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].vin, vecs[i].ordy, vecs[i].fl, mk(vecs[i].pc, vecs[i].ctl));
            chk($sformatf("vec%0d_in_ready", i), {63'd0, in_ready}, {63'd0, vecs[i].e_ir});
            chk($sformatf("vec%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].e_ov});
            if (i == 12)
                chk("flush_gating", {61'd0, memRead, memWrite, regWrite}, 64'd0);
        end
        check_state();

        // Async reset asserted between edges while FULL
        cycle(1'b1, 1'b0, 1'b0, mk(32'h50, 5'b00111));
        cycle(1'b1, 1'b0, 1'b0, mk(32'h54, 5'b00111));
        chk("full_before_reset", {62'd0, in_ready, out_valid}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("async_rst_pcpp", {32'd0, pcpp}, 64'd0);
        sb.delete();
        drive(1'b0, 1'b1, 1'b0, idle);
        @(posedge clock);
        reset_n = 1'b1;

`ifdef IDEX_PERF_CNT_EN
        // Two bubble edges (idle, then the accepting edge), three stall edges.
        cycle(1'b0, 1'b1, 1'b0, idle);
        cycle(1'b1, 1'b0, 1'b0, mk(32'h60, 5'b00000));
        cycle(1'b0, 1'b0, 1'b0, idle);
        cycle(1'b0, 1'b0, 1'b0, idle);
        cycle(1'b0, 1'b0, 1'b0, idle);
        chk("stallCount", {32'd0, stallCount}, 64'd3);
        chk("bubbleCount", {32'd0, bubbleCount}, 64'd2);
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        cycle(1'b0, 1'b0, 1'b0, idle);
        chk("stall_to_max", {32'd0, stallCount}, 64'hFFFF_FFFF);
        cycle(1'b0, 1'b0, 1'b0, idle);
        chk("stall_saturate", {32'd0, stallCount}, 64'hFFFF_FFFF);
        cycle(1'b1, 1'b1, 1'b1, idle);
        chk("flush_keeps_cnt", {32'd0, stallCount}, 64'hFFFF_FFFF);
`endif

        // Post-reset streaming sanity
        cycle(1'b1, 1'b1, 1'b0, mk(32'h70, 5'b10110));
        cycle(1'b1, 1'b1, 1'b0, mk(32'h74, 5'b01101));
        cycle(1'b0, 1'b1, 1'b0, idle);
        check_state();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
